shift_reg_ser_in: RTL and testbench
===================================

Name: shift_reg_ser_in

Overview:
Serial-in, parallel-out receiver. It is the far end of the parallel-in shift register transmitter, which emits bit 0 first and shifts right on each shift strobe. The block samples one bit per strobe and rebuilds an M-bit word, LSB first. Each completed word goes into a holding register with a valid/ready handshake, and a sticky overrun flag records words lost to backpressure.

Parameters:
M, 5, word width in data bits (M >= 2)
CW, $clog2(M+1), bit-counter width (derived; do not override)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
bit_in  input  1  serial data, sampled only when shift=1
shift  input  1  sample strobe, one bit per cycle with shift=1
clear  input  1  aborts the partial word and clears overrun
ready  input  1  downstream accepts bus_out when valid=1
bus_out  output  M  last completed word, bit 0 = first bit received
valid  output  1  bus_out holds an unconsumed word
overrun  output  1  sticky: a completed word was dropped
bit_cnt  output  CW  number of bits collected in the current partial word
parity_err  output  1  see Optional Feature

Behaviour:
- Reset values: sr=0, bit_cnt=0, bus_out=0, valid=0, overrun=0, parity_err=0. Reset overrides every other input, including mid-word.
- Receive FSM, two states:
  - IDLE: bit_cnt=0.
  - RECV: 0<bit_cnt<M.
  - IDLE -> RECV on the first shift. RECV -> IDLE on completion or clear.
- Input priority per cycle: reset > clear > shift.
- On shift (not completing):
  - sr <= {bit_in, sr[M-1:1]}
  - bit_cnt <= bit_cnt+1
- Completion is the shift with bit_cnt==M-1. Define word = {bit_in, sr[M-1:1]}. Then:
  - bit_cnt <= 0 and sr <= 0.
  - If the holding register is free (valid=0, or valid&&ready this cycle): bus_out <= word, valid <= 1. bus_out and valid appear 1 cycle after the completing shift.
  - Otherwise: word dropped, bus_out unchanged, overrun <= 1.
- Handshake:
  - Transfer occurs when valid&&ready.
  - On transfer with no simultaneous completion: valid <= 0, and bus_out holds its value.
  - Transfer and completion in the same cycle: the new word is loaded and valid stays 1, with no bubble and no overrun.
  - ready is ignored while valid=0.
- Cycles with shift=0 hold sr and bit_cnt; there is no timeout.
- clear:
  - sr <= 0, bit_cnt <= 0, overrun <= 0.
  - bus_out and valid are unaffected, so a pending word survives clear.
  - A shift in the same cycle as clear is discarded.
- Back-to-back shifts every cycle are supported at full rate: one word per M cycles.
- bit_cnt never reaches M; its legal range is 0..M-1.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - Each frame is M data bits followed by one even-parity bit, and bit_cnt counts 0..M.
  - Completion happens on the parity-bit shift, i.e. the shift with bit_cnt==M.
  - On completion, parity_err <= (XOR of the M data bits) ^ parity bit. It is registered alongside bus_out, updates only when bus_out loads, and resets to 0.
  - Dropped frames do not update parity_err.
- Undefined:
  - Frames are M bits and completion is at bit_cnt==M-1, as above.
  - parity_err is a constant 0 and there is no parity logic.

Test Plan:
- Basic word, M=5, ready=1: shift bits 0,1,1,0,1 on consecutive cycles. Required: the cycle after the 5th shift, bus_out=5'b10110, valid=1, bit_cnt=0, overrun=0.
- Gapped strobes: the same bits with 2 idle cycles between each shift. Required: bit_cnt steps 1,2,3,4 and holds during gaps; bus_out=5'b10110 arrives 1 cycle after the last shift.
- Backpressure, ready=0:
  - Send 5'b00011, then 5'b11100. Required: after word 1, valid=1 and bus_out=5'b00011. After word 2, overrun=1 and bus_out is still 5'b00011.
  - Then ready=1 for 1 cycle. Required: valid=0.
  - Then clear. Required: overrun=0.
- Completion plus transfer: with valid=1 holding 5'b00001, assert ready in the exact cycle the 5th bit of 5'b11111 is shifted. Required: next cycle bus_out=5'b11111, valid=1, overrun=0.
- Abort and reset:
  - Shift 3 bits (1,1,1), assert clear, then shift 0,0,1,0,0. Required: bus_out=5'b00100.
  - Separately, shift 2 bits then assert reset. Required: all outputs 0 and bit_cnt=0.
- With SIPO_PARITY_EN, M=5:
  - Send data 1,1,0,0,0 with parity 0. Required: bus_out=5'b00011, parity_err=0.
  - Send the same data with parity 1. Required: parity_err=1.

Source files
------------

// File: rtl/shift_reg_ser_in.sv
// Serial-in, parallel-out receiver: rebuilds LSB-first M-bit words into a valid/ready holding register.
// Optional even-parity framing (one extra bit per frame) is enabled with `define SIPO_PARITY_EN.
module shift_reg_ser_in #(
  parameter int M  = 5,
  parameter int CW = $clog2(M+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_in,
  input  logic          shift,
  input  logic          clear,
  input  logic          ready,
  output logic [M-1:0]  bus_out,
  output logic          valid,
  output logic          overrun,
  output logic [CW-1:0] bit_cnt,
  output logic          parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int            SRW  = M;
  localparam logic [CW-1:0] LAST = CW'(M);
`else
  // The final data bit is taken straight from bit_in, so only M-1 bits need storing.
  localparam int            SRW  = M - 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);
`endif

  typedef enum logic {IDLE, RECV} state_t;

  state_t         state, state_d;
  logic [SRW-1:0] sr;
  logic [SRW:0]   sh;
  logic [M-1:0]   word;
  logic           do_shift, complete, xfer, load;

  assign sh   = {bit_in, sr};
  assign word = sh[M-1:0];
  assign xfer = valid && ready;
  assign load = complete && (!valid || ready);

  always_comb begin
    state_d  = state;
    do_shift = 1'b0;
    complete = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else if (shift) begin
      if (bit_cnt == LAST) begin
        complete = 1'b1;
        state_d  = IDLE;
      end else begin
        do_shift = 1'b1;
        state_d  = RECV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      bus_out <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      // A load in the same cycle as a transfer overrides the drop, so no bubble.
      if (xfer) valid <= 1'b0;
      if (load) begin
        bus_out <= word;
        valid   <= 1'b1;
      end
      if (clear) begin
        sr      <= '0;
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (complete) begin
        sr      <= '0;
        bit_cnt <= '0;
        if (!load) overrun <= 1'b1;
      end else if (do_shift) begin
        sr      <= sh[SRW:1];
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_q;

  // Even parity: XOR over data plus parity bit is 0 for a good frame.
  always_ff @(posedge clk) begin
    if (reset)     par_q <= 1'b0;
    else if (load) par_q <= ^sh;
  end

  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_ser_in.sv
// Bench for shift_reg_ser_in: directed scenarios plus randomized traffic against a queue-based model.
module tb_shift_reg_ser_in;
  localparam int M  = 5;
  localparam int CW = $clog2(M+1);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = M + 1;
`else
  localparam int FRAME = M;
`endif

  logic          clk = 1'b0;
  logic          reset, bit_in, shift, clear, ready;
  logic [M-1:0]  bus_out;
  logic          valid, overrun, parity_err;
  logic [CW-1:0] bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: collected bits as a queue, holding register as plain variables
  bit           q[$];
  logic [M-1:0] m_bus;
  bit           m_vld, m_ovr, m_par;

  shift_reg_ser_in #(.M(M)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .shift(shift), .clear(clear),
    .ready(ready), .bus_out(bus_out), .valid(valid), .overrun(overrun),
    .bit_cnt(bit_cnt), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic model(input bit rs, input bit b, input bit s, input bit c, input bit r);
    bit loaded = 0;
    logic [M-1:0] w;
    bit p;
    if (rs) begin
      q.delete(); m_bus = '0; m_vld = 0; m_ovr = 0; m_par = 0;
      return;
    end
    if (c) begin
      q.delete(); m_ovr = 0;
    end else if (s) begin
      q.push_back(b);
      if (q.size() == FRAME) begin
        for (int i = 0; i < M; i++) w[i] = q[i];
        p = ^w;
        if (FRAME > M) p = p ^ q[M];
        if (!m_vld || r) begin
          m_bus = w; m_vld = 1; loaded = 1;
          if (FRAME > M) m_par = p;
        end else begin
          m_ovr = 1;
        end
        q.delete();
      end
    end
    if (m_vld && r && !loaded) m_vld = 0;
  endtask

  // drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input bit rs, input bit b, input bit s, input bit c, input bit r);
    reset = rs; bit_in = b; shift = s; clear = c; ready = r;
    model(rs, b, s, c, r);
    @(posedge clk); #1;
  endtask

  function automatic logic [FRAME-1:0] frame_of(input logic [M-1:0] w, input bit p);
    logic [FRAME-1:0] f;
    f[M-1:0] = w;
    if (FRAME > M) f[FRAME-1] = p;
    return f;
  endfunction

  task automatic send(input logic [M-1:0] w, input bit r);
    logic [FRAME-1:0] f = frame_of(w, ^w);
    for (int i = 0; i < FRAME; i++) step(0, f[i], 1, 0, r);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1);
    n_cmp++;
    if ({bus_out, valid, overrun, bit_cnt, parity_err} !== '0) begin
      n_bad++;
      $display("FAIL reset: got bus=%b v=%b ov=%b cnt=%0d pe=%b, want all 0",
               bus_out, valid, overrun, bit_cnt, parity_err);
    end
  endtask

  task automatic test_basic;
    logic [M-1:0] w = 5'b10110;
    step(0, 0, 0, 1, 1);
    send(w, 1);
    n_cmp++;
    if ({bus_out, valid, overrun, bit_cnt} !== {5'b10110, 1'b1, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL basic: got bus=%b v=%b ov=%b cnt=%0d, want 10110 1 0 0",
               bus_out, valid, overrun, bit_cnt);
    end
  endtask

  task automatic test_gapped;
    logic [FRAME-1:0] f = frame_of(5'b10110, ^5'b10110);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < FRAME; i++) begin
      step(0, f[i], 1, 0, 1);
      if (i == FRAME - 1) begin
        n_cmp++;
        if ({bus_out, valid, bit_cnt} !== {5'b10110, 1'b1, CW'(0)}) begin
          n_bad++;
          $display("FAIL gapped_word: got bus=%b v=%b cnt=%0d, want 10110 1 0", bus_out, valid, bit_cnt);
        end
      end else begin
        for (int g = 0; g < 2; g++) begin
          step(0, 1, 0, 0, 1);
          n_cmp++;
          if (bit_cnt !== CW'(i + 1)) begin
            n_bad++;
            $display("FAIL gapped_cnt: got %0d, want %0d", bit_cnt, i + 1);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    step(0, 0, 0, 1, 1);
    send(5'b00011, 0);
    n_cmp++;
    if ({valid, bus_out} !== {1'b1, 5'b00011}) begin
      n_bad++;
      $display("FAIL bp_word1: got v=%b bus=%b, want 1 00011", valid, bus_out);
    end
    send(5'b11100, 0);
    n_cmp++;
    if ({overrun, valid, bus_out} !== {1'b1, 1'b1, 5'b00011}) begin
      n_bad++;
      $display("FAIL bp_overrun: got ov=%b v=%b bus=%b, want 1 1 00011", overrun, valid, bus_out);
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if ({valid, bus_out} !== {1'b0, 5'b00011}) begin
      n_bad++;
      $display("FAIL bp_drain: got v=%b bus=%b, want 0 00011", valid, bus_out);
    end
    step(0, 0, 0, 1, 0);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_clear: got ov=%b, want 0", overrun);
    end
  endtask

  task automatic test_complete_xfer;
    logic [FRAME-1:0] f = frame_of(5'b11111, 1'b1);
    step(0, 0, 0, 1, 1);
    send(5'b00001, 0);
    for (int i = 0; i < FRAME; i++) step(0, f[i], 1, 0, i == FRAME - 1);
    n_cmp++;
    if ({bus_out, valid, overrun} !== {5'b11111, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL xfer_complete: got bus=%b v=%b ov=%b, want 11111 1 0", bus_out, valid, overrun);
    end
  endtask

  task automatic test_clear_abort;
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    n_cmp++;
    if (bit_cnt !== CW'(0)) begin
      n_bad++;
      $display("FAIL clear_cnt: got %0d, want 0", bit_cnt);
    end
    send(5'b00100, 0);
    n_cmp++;
    if ({bus_out, valid} !== {5'b00100, 1'b1}) begin
      n_bad++;
      $display("FAIL clear_word: got bus=%b v=%b, want 00100 1", bus_out, valid);
    end
  endtask

  task automatic test_reset_midword;
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    n_cmp++;
    if ({bus_out, valid, overrun, bit_cnt, parity_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got bus=%b v=%b ov=%b cnt=%0d pe=%b, want all 0",
               bus_out, valid, overrun, bit_cnt, parity_err);
    end
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity;
    logic [FRAME-1:0] f;
    for (int p = 0; p < 2; p++) begin
      step(0, 0, 0, 1, 1);
      f = frame_of(5'b00011, p[0]);
      for (int i = 0; i < FRAME; i++) step(0, f[i], 1, 0, 1);
      n_cmp++;
      if ({bus_out, parity_err} !== {5'b00011, p[0]}) begin
        n_bad++;
        $display("FAIL parity_%0d: got bus=%b pe=%b, want 00011 %0d", p, bus_out, parity_err, p);
      end
    end
  endtask
`endif

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
      n_cmp++;
      if ({bus_out, valid, overrun, bit_cnt, parity_err} !==
          {m_bus, m_vld, m_ovr, CW'(q.size()), m_par}) begin
        n_bad++;
        $display("FAIL random@%0d: got bus=%b v=%b ov=%b cnt=%0d pe=%b, want %b %b %b %0d %b",
                 n, bus_out, valid, overrun, bit_cnt, parity_err,
                 m_bus, m_vld, m_ovr, q.size(), m_par);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_complete_xfer();
    test_clear_abort();
    test_reset_midword();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
